// File: rtl/instr_disp_pkg.sv
// Shared types and constants for the instruction dispatcher and its FIFO.
package instr_disp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRelease,
    StBackoff
  } disp_state_e;

  // Instruction field slices as seen by the instruction register.
  localparam int unsigned MNM_MSB = 7;
  localparam int unsigned MNM_LSB = 6;
  localparam int unsigned WA_MSB  = 5;
  localparam int unsigned WA_LSB  = 4;
  localparam int unsigned RD_MSB  = 3;
  localparam int unsigned RD_LSB  = 0;

  localparam int unsigned ACK_MIN_LATENCY = 3;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO buffering upstream instructions; head is the oldest entry.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_dispatcher.sv
// Issues buffered instructions to the instruction register with an ena/ack handshake,
// ack timeout, bounded retry and done/err reporting.
module instruction_dispatcher
  import instr_disp_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 8,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] data_out,
  output logic       ena,
  input  logic       ack,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] err_count
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic       push, pop, full, empty;
  logic [7:0] head;

  disp_state_e   state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          ena_q, ena_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [3:0]    errc_q, errc_d;
  logic          accept, timeout, exhausted, discard;

  assign in_ready = rst && !full;
  assign push     = in_valid && in_ready;

  instr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(in_data),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    // A stale ack held over from before ISSUE is never taken in the first ISSUE cycle.
    accept    = (state_q == StIssue) && ack && (tcnt_q != '0);
    timeout   = (state_q == StIssue) && !accept && (tcnt_q == TW'(TIMEOUT - 1));
    exhausted = (retry_q >= RW'(MAX_RETRY));
    discard   = timeout && exhausted;
    pop       = accept || discard;

    state_d = state_q;
    data_d  = data_q;
    ena_d   = ena_q;
    tcnt_d  = tcnt_q;
    retry_d = retry_q;
    errc_d  = errc_q;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StIssue;
          data_d  = head;
          ena_d   = 1'b1;
          tcnt_d  = '0;
          retry_d = '0;
        end
      end
      StIssue: begin
        if (accept) begin
          state_d = StRelease;
          ena_d   = 1'b0;
        end else if (timeout) begin
          state_d = StBackoff;
          ena_d   = 1'b0;
          tcnt_d  = '0;
          if (exhausted) begin
            retry_d = '0;
            if (errc_q != 4'hF) errc_d = errc_q + 4'd1;
          end else begin
            retry_d = retry_q + RW'(1);
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StRelease: begin
        if (!ack) begin
          if (!empty) begin
            state_d = StIssue;
            data_d  = head;
            ena_d   = 1'b1;
            tcnt_d  = '0;
            retry_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StBackoff: begin
        // After a discard the popped head is already the next entry; otherwise it is unchanged.
        if (!empty) begin
          state_d = StIssue;
          data_d  = head;
          ena_d   = 1'b1;
          tcnt_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      ena_q   <= 1'b0;
      tcnt_q  <= '0;
      retry_q <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ena_q   <= ena_d;
      tcnt_q  <= tcnt_d;
      retry_q <= retry_d;
      errc_q  <= errc_d;
    end
  end

  assign data_out  = data_q;
  assign ena       = ena_q;
  assign err_count = errc_q;
  assign busy      = !empty || (state_q != StIdle);
  assign done      = accept;
  assign err       = discard;

endmodule
